// File: rtl/axi_read_scheduler_if.sv
// Bundle of the AR request/ready, slave AR handshake, selected R-channel
// status and mux-select signals around the shared AXI read scheduler.
interface axi_read_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              arvalid_m0;
    logic              arvalid_m1;
    logic [ADDR_W-1:0] araddr_m0;
    logic [ADDR_W-1:0] araddr_m1;
    logic [LEN_W-1:0]  arlen_m0;
    logic [LEN_W-1:0]  arlen_m1;
    logic              arready_m0;
    logic              arready_m1;
    logic              arvalid_s0;
    logic              arvalid_s1;
    logic              arvalid_s2;
    logic              arready_s0;
    logic              arready_s1;
    logic              arready_s2;
    logic              rvalid_sel;
    logic              rready_sel;
    logic              rlast_sel;
    logic              ar_master_sel;
    logic [1:0]        r_slave_sel;
    logic              busy;
    logic              len_err;

    // Scheduler side: takes requests and R status, drives gating and selects.
    modport slave (
        input  arvalid_m0, arvalid_m1, araddr_m0, araddr_m1, arlen_m0, arlen_m1,
        input  arready_s0, arready_s1, arready_s2,
        input  rvalid_sel, rready_sel, rlast_sel,
        output arready_m0, arready_m1,
        output arvalid_s0, arvalid_s1, arvalid_s2,
        output ar_master_sel, r_slave_sel, busy, len_err
    );

    // Environment side: masters, slaves and the R datapath mux.
    modport master (
        output arvalid_m0, arvalid_m1, araddr_m0, araddr_m1, arlen_m0, arlen_m1,
        output arready_s0, arready_s1, arready_s2,
        output rvalid_sel, rready_sel, rlast_sel,
        input  arready_m0, arready_m1,
        input  arvalid_s0, arvalid_s1, arvalid_s2,
        input  ar_master_sel, r_slave_sel, busy, len_err
    );
endinterface

// File: rtl/axi_read_scheduler.sv
// Round-robin AR arbiter and sequencer for two masters and three slaves.
// One read is outstanding at a time: the grant is held from the AR
// handshake until the last R beat, and burst length is cross-checked
// against RLAST.
//
// state | meaning
// IDLE  | no grant; selects hold their last values
// ADDR  | grant latched, AR valid/ready gated to the decoded slave
// DATA  | AR accepted, counting R beats until RLAST
module axi_read_scheduler #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input logic             clk,
    input logic             rst,
    axi_read_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state;
    logic             prio;
    logic             master_sel_q;
    logic [1:0]       slave_sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic             busy_q;
    logic             len_err_q;

    logic             grant_m1;
    logic [15:0]      win_hi;
    logic [LEN_W-1:0] win_len;
    logic [1:0]       win_slave;
    logic             granted_valid;
    logic             sel_ready;
    logic             in_addr;
    logic             ar_hs;
    logic             beat;

    // Arbitration and address decode for the request about to be granted.
    always_comb begin
        grant_m1  = bus.arvalid_m1 & (~bus.arvalid_m0 | prio);
        win_hi    = grant_m1 ? bus.araddr_m1[ADDR_W-1 -: 16] : bus.araddr_m0[ADDR_W-1 -: 16];
        win_len   = grant_m1 ? bus.arlen_m1 : bus.arlen_m0;
        win_slave = 2'd2;
        if (win_hi == 16'h0000)
            win_slave = 2'd0;
        else if (win_hi == 16'h0001)
            win_slave = 2'd1;
    end

    // AR gating through the shared mux, driven from latched selects.
    always_comb begin
        in_addr       = (state == ADDR);
        granted_valid = master_sel_q ? bus.arvalid_m1 : bus.arvalid_m0;
        case (slave_sel_q)
            2'd0:    sel_ready = bus.arready_s0;
            2'd1:    sel_ready = bus.arready_s1;
            default: sel_ready = bus.arready_s2;
        endcase
        ar_hs = in_addr & granted_valid & sel_ready;
        beat  = bus.rvalid_sel & bus.rready_sel;
    end

    assign bus.arvalid_s0    = in_addr & granted_valid & (slave_sel_q == 2'd0);
    assign bus.arvalid_s1    = in_addr & granted_valid & (slave_sel_q == 2'd1);
    assign bus.arvalid_s2    = in_addr & granted_valid & (slave_sel_q == 2'd2);
    assign bus.arready_m0    = in_addr & ~master_sel_q & sel_ready;
    assign bus.arready_m1    = in_addr & master_sel_q & sel_ready;
    assign bus.ar_master_sel = master_sel_q;
    assign bus.r_slave_sel   = slave_sel_q;
    assign bus.busy          = busy_q;
    assign bus.len_err       = len_err_q;

    // Sequencer: grant, AR handshake, beat counting and priority rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            master_sel_q <= 1'b0;
            slave_sel_q  <= 2'd0;
            len_q        <= '0;
            beat_cnt     <= '0;
            busy_q       <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.arvalid_m0 | bus.arvalid_m1) begin
                        state        <= ADDR;
                        busy_q       <= 1'b1;
                        master_sel_q <= grant_m1;
                        slave_sel_q  <= win_slave;
                        len_q        <= win_len;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state    <= DATA;
                        beat_cnt <= '0;
                    end else if (!granted_valid) begin
                        // master withdrew its request; no one was served
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        len_err_q <= bus.rlast_sel ? (beat_cnt != len_q) : (beat_cnt == len_q);
                        if (bus.rlast_sel) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            prio   <= ~master_sel_q;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
